// File: rtl/vga_frame_scanner.sv
// VGA raster timing generator that streams the pixel buffer out in raster order.
// Sync and blank are delayed to line up with the buffer's read latency.
module vga_frame_scanner #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              frame_done
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RD_LAT-1:0] hs_pipe_q, vs_pipe_q, act_pipe_q;
  logic              scanning, h_end, frame_end, hs_raw, vs_raw, act_raw;

  assign scanning  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign h_end     = (h_cnt_q == H_LAST);
  assign frame_end = scanning && h_end && (v_cnt_q == V_LAST);
  assign act_raw   = scanning && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_raw    = !((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
  assign vs_raw    = !((v_cnt_q >= V_SS) && (v_cnt_q < V_SE));

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
    if (scanning) begin
      // The frame boundary decides run/idle, so a frame is never cut short.
      if (frame_end) begin
        state_d = enable ? ST_RUN : ST_IDLE;
        h_cnt_d = '0;
        v_cnt_d = '0;
        addr_d  = '0;
      end else begin
        if (h_end) begin
          h_cnt_d = '0;
          v_cnt_d = v_cnt_q + 1'b1;
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
        if (act_raw) addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      addr_q     <= '0;
      hs_pipe_q  <= '1;
      vs_pipe_q  <= '1;
      act_pipe_q <= '0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      addr_q        <= addr_d;
      hs_pipe_q[0]  <= hs_raw;
      vs_pipe_q[0]  <= vs_raw;
      act_pipe_q[0] <= act_raw;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        hs_pipe_q[i]  <= hs_pipe_q[i-1];
        vs_pipe_q[i]  <= vs_pipe_q[i-1];
        act_pipe_q[i] <= act_pipe_q[i-1];
      end
    end
  end

  assign rd_en       = act_raw;
  assign rd_addr     = addr_q;
  assign frame_done  = frame_end;
  assign VGA_HS      = hs_pipe_q[RD_LAT-1];
  assign VGA_VS      = vs_pipe_q[RD_LAT-1];
  assign VGA_BLANK_N = act_pipe_q[RD_LAT-1];
  assign VGA_R       = VGA_BLANK_N ? rd_data[23:16] : 8'd0;
  assign VGA_G       = VGA_BLANK_N ? rd_data[15:8]  : 8'd0;
  assign VGA_B       = VGA_BLANK_N ? rd_data[7:0]   : 8'd0;

endmodule
